// File: rtl/dram_arbiter_if.sv
// ============================================================================
//  Module      : dram_arbiter_if
//  Description : Bus bundle for dram_arbiter. Groups the CPU MEM-stage request,
//                the debug/loader request, the DRAM port and the owner flag.
//                slave  : seen from the arbiter (requests in, responses out)
//                master : seen from the surrounding system / testbench
//  Signals     : cpu_req_i/we_i/adr_i[16]/wd_i[32]/sel_i[2] -> cpu_rdata_o[32],
//                cpu_stall_o, cpu_err_o
//                dbg_req_i/we_i/adr_i[16]/wd_i[32]/sel_i[2] -> dbg_ack_o,
//                dbg_rdata_o[32], dbg_err_o
//                mem_we_o, mem_adr_o[16], mem_wd_o[32], mem_sel_o[2] <- mem_rdata_i[32]
//                owner_o (0 = CPU owns the DRAM port, 1 = debug owns it)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dram_arbiter_if;
    // CPU MEM-stage request
    logic        cpu_req_i;
    logic        cpu_we_i;
    logic [15:0] cpu_adr_i;
    logic [31:0] cpu_wd_i;
    logic [1:0]  cpu_sel_i;
    logic [31:0] cpu_rdata_o;
    logic        cpu_stall_o;
    logic        cpu_err_o;

    // Debug / loader request
    logic        dbg_req_i;
    logic        dbg_we_i;
    logic [15:0] dbg_adr_i;
    logic [31:0] dbg_wd_i;
    logic [1:0]  dbg_sel_i;
    logic        dbg_ack_o;
    logic [31:0] dbg_rdata_o;
    logic        dbg_err_o;

    // DRAM port
    logic        mem_we_o;
    logic [15:0] mem_adr_o;
    logic [31:0] mem_wd_o;
    logic [1:0]  mem_sel_o;
    logic [31:0] mem_rdata_i;

    logic        owner_o;

    modport slave (
        input  cpu_req_i, cpu_we_i, cpu_adr_i, cpu_wd_i, cpu_sel_i,
        output cpu_rdata_o, cpu_stall_o, cpu_err_o,
        input  dbg_req_i, dbg_we_i, dbg_adr_i, dbg_wd_i, dbg_sel_i,
        output dbg_ack_o, dbg_rdata_o, dbg_err_o,
        output mem_we_o, mem_adr_o, mem_wd_o, mem_sel_o,
        input  mem_rdata_i,
        output owner_o
    );

    modport master (
        output cpu_req_i, cpu_we_i, cpu_adr_i, cpu_wd_i, cpu_sel_i,
        input  cpu_rdata_o, cpu_stall_o, cpu_err_o,
        output dbg_req_i, dbg_we_i, dbg_adr_i, dbg_wd_i, dbg_sel_i,
        input  dbg_ack_o, dbg_rdata_o, dbg_err_o,
        input  mem_we_o, mem_adr_o, mem_wd_o, mem_sel_o,
        output mem_rdata_i,
        input  owner_o
    );
endinterface

`default_nettype wire

// File: rtl/dram_arbiter.sv
// ============================================================================
//  Module      : dram_arbiter
//  Description : Two-port arbiter sharing one DRAM port between the pipeline
//                MEM stage (zero added latency) and a debug/loader port.
//                Checks address range and alignment, blocks illegal stores,
//                and bounds debug starvation with a saturating wait counter.
//  Ports       : clk_i    - clock
//                reset_i  - asynchronous active-high reset
//                bus      - dram_arbiter_if.slave (CPU, debug, DRAM, owner)
//  Parameters  : BASE_ADDR    - lowest legal data address
//                DBG_WAIT_MAX - contended cycles before debug preempts (1..15)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dram_arbiter #(
    parameter logic [15:0] BASE_ADDR    = 16'h4000,
    parameter int unsigned DBG_WAIT_MAX = 4
) (
    input  wire                   clk_i,
    input  wire                   reset_i,
    dram_arbiter_if.slave         bus
);

    localparam logic [3:0] C_WAIT_MAX = DBG_WAIT_MAX[3:0];

    typedef enum logic [0:0] {
        S_CPU = 1'b0,
        S_DBG = 1'b1
    } state_t;

    state_t      state_q,     state_d;
    logic [3:0]  wait_cnt_q,  wait_cnt_d;
    logic        dbg_ack_q,   dbg_ack_d;
    logic [31:0] dbg_rdata_q, dbg_rdata_d;
    logic        dbg_err_q,   dbg_err_d;

    logic        w_cpu_legal;
    logic        w_dbg_legal;

    // Range plus natural alignment for the requested size; sel 10 never legal.
    function automatic logic is_legal(input logic [15:0] adr, input logic [1:0] sel);
        logic ok_align;
        case (sel)
            2'b00:   ok_align = 1'b1;
            2'b01:   ok_align = (adr[0] == 1'b0);
            2'b11:   ok_align = (adr[1:0] == 2'b00);
            default: ok_align = 1'b0;
        endcase
        return ok_align && (adr >= BASE_ADDR);
    endfunction

    assign w_cpu_legal = is_legal(bus.cpu_adr_i, bus.cpu_sel_i);
    assign w_dbg_legal = is_legal(bus.dbg_adr_i, bus.dbg_sel_i);

    always_comb begin
        state_d         = state_q;
        wait_cnt_d      = wait_cnt_q;
        dbg_ack_d       = 1'b0;
        dbg_rdata_d     = dbg_rdata_q;
        dbg_err_d       = dbg_err_q;

        bus.mem_we_o    = 1'b0;
        bus.mem_adr_o   = bus.cpu_adr_i;
        bus.mem_wd_o    = bus.cpu_wd_i;
        bus.mem_sel_o   = bus.cpu_sel_i;
        bus.cpu_rdata_o = 32'h0;
        bus.cpu_stall_o = 1'b0;
        bus.cpu_err_o   = 1'b0;

        case (state_q)
            S_CPU: begin
                bus.mem_we_o    = bus.cpu_req_i & bus.cpu_we_i & w_cpu_legal;
                bus.cpu_rdata_o = w_cpu_legal ? bus.mem_rdata_i : 32'h0;
                bus.cpu_err_o   = bus.cpu_req_i & ~w_cpu_legal;

                // Count only contended cycles; hold at the limit until preemption.
                if (bus.dbg_req_i && bus.cpu_req_i && (wait_cnt_q != C_WAIT_MAX)) begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end

                // The CPU is still served in the cycle that triggers preemption;
                // the stall lands in the following S_DBG cycle.
                if (bus.dbg_req_i && (!bus.cpu_req_i || (wait_cnt_q == C_WAIT_MAX))) begin
                    state_d    = S_DBG;
                    wait_cnt_d = 4'd0;
                end
            end

            S_DBG: begin
                bus.mem_adr_o   = bus.dbg_adr_i;
                bus.mem_wd_o    = bus.dbg_wd_i;
                bus.mem_sel_o   = bus.dbg_sel_i;
                bus.mem_we_o    = bus.dbg_req_i & bus.dbg_we_i & w_dbg_legal;
                bus.cpu_stall_o = bus.cpu_req_i;

                // Single-cycle debug tenure: always hand the port back.
                state_d     = S_CPU;
                dbg_ack_d   = 1'b1;
                dbg_err_d   = ~w_dbg_legal;
                dbg_rdata_d = (w_dbg_legal && !bus.dbg_we_i) ? bus.mem_rdata_i : 32'h0;
            end

            default: begin
                state_d = S_CPU;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= S_CPU;
            wait_cnt_q  <= 4'd0;
            dbg_ack_q   <= 1'b0;
            dbg_rdata_q <= 32'h0;
            dbg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            dbg_ack_q   <= dbg_ack_d;
            dbg_rdata_q <= dbg_rdata_d;
            dbg_err_q   <= dbg_err_d;
        end
    end

    assign bus.dbg_ack_o   = dbg_ack_q;
    assign bus.dbg_rdata_o = dbg_rdata_q;
    assign bus.dbg_err_o   = dbg_err_q;
    assign bus.owner_o     = (state_q == S_DBG);

endmodule

`default_nettype wire

// File: tb/tb_dram_arbiter.sv
// ============================================================================
//  Module      : tb_dram_arbiter
//  Description : Directed testbench for dram_arbiter with a byte-addressed
//                64 KB DRAM model (combinational read, write on clock edge).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dram_arbiter;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    logic [7:0] mem_b [0:65535];

    dram_arbiter_if bus ();

    dram_arbiter #(
        .BASE_ADDR    (16'h4000),
        .DBG_WAIT_MAX (4)
    ) u_dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DRAM model: word-aligned combinational read, sized write on the edge.
    wire [15:0] w_ra = {bus.mem_adr_o[15:2], 2'b00};
    assign bus.mem_rdata_i = {mem_b[w_ra + 16'd3], mem_b[w_ra + 16'd2],
                              mem_b[w_ra + 16'd1], mem_b[w_ra]};

    always @(posedge clk) begin
        if (bus.mem_we_o) begin
            mem_b[bus.mem_adr_o] <= bus.mem_wd_o[7:0];
            if (bus.mem_sel_o != 2'b00)
                mem_b[bus.mem_adr_o + 16'd1] <= bus.mem_wd_o[15:8];
            if (bus.mem_sel_o == 2'b11) begin
                mem_b[bus.mem_adr_o + 16'd2] <= bus.mem_wd_o[23:16];
                mem_b[bus.mem_adr_o + 16'd3] <= bus.mem_wd_o[31:24];
            end
        end
    end

    function automatic logic [31:0] word_at(input logic [15:0] a);
        return {mem_b[a + 16'd3], mem_b[a + 16'd2], mem_b[a + 16'd1], mem_b[a]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_idle();
        bus.cpu_req_i = 1'b0; bus.cpu_we_i = 1'b0; bus.cpu_adr_i = 16'h4000;
        bus.cpu_wd_i = 32'h0; bus.cpu_sel_i = 2'b11;
    endtask

    task automatic dbg_set(input logic req, input logic we, input logic [15:0] adr,
                           input logic [31:0] wd, input logic [1:0] sel);
        bus.dbg_req_i = req; bus.dbg_we_i = we; bus.dbg_adr_i = adr;
        bus.dbg_wd_i = wd; bus.dbg_sel_i = sel;
    endtask

    task automatic test_reset();
        cpu_idle();
        dbg_set(1'b0, 1'b0, 16'h4000, 32'h0, 2'b11);
        rst = 1'b1;
        #2;
        total++; if (bus.owner_o !== 1'b0) begin bad++; $display("FAIL reset_owner got=%b exp=0", bus.owner_o); end
        total++; if (bus.dbg_ack_o !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b exp=0", bus.dbg_ack_o); end
        total++; if (bus.dbg_rdata_o !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", bus.dbg_rdata_o); end
        total++; if (bus.dbg_err_o !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", bus.dbg_err_o); end
        total++; if (bus.cpu_stall_o !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", bus.cpu_stall_o); end
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_cpu_only();
        bus.cpu_req_i = 1'b1; bus.cpu_we_i = 1'b1; bus.cpu_adr_i = 16'h4010;
        bus.cpu_wd_i = 32'h11223344; bus.cpu_sel_i = 2'b11;
        #2;
        total++; if (bus.mem_we_o !== 1'b1) begin bad++; $display("FAIL cpu_sw_we got=%b exp=1", bus.mem_we_o); end
        total++; if (bus.cpu_err_o !== 1'b0) begin bad++; $display("FAIL cpu_sw_err got=%b exp=0", bus.cpu_err_o); end
        total++; if (bus.cpu_stall_o !== 1'b0) begin bad++; $display("FAIL cpu_sw_stall got=%b exp=0", bus.cpu_stall_o); end
        tick();
        bus.cpu_we_i = 1'b0;
        #2;
        total++; if (bus.cpu_rdata_o !== 32'h11223344) begin bad++; $display("FAIL cpu_lw_data got=%h exp=11223344", bus.cpu_rdata_o); end
        total++; if (bus.owner_o !== 1'b0) begin bad++; $display("FAIL cpu_lw_owner got=%b exp=0", bus.owner_o); end
        total++; if (bus.mem_we_o !== 1'b0) begin bad++; $display("FAIL cpu_lw_we got=%b exp=0", bus.mem_we_o); end
        tick();
        cpu_idle();
        tick();
    endtask

    task automatic test_dbg_idle();
        // write: request at t, S_DBG at t+1, ack at t+2
        dbg_set(1'b1, 1'b1, 16'h4020, 32'hDEADBEEF, 2'b11);
        #2;
        total++; if (bus.owner_o !== 1'b0) begin bad++; $display("FAIL dbgw_t0_owner got=%b exp=0", bus.owner_o); end
        tick(); #2;
        total++; if (bus.owner_o !== 1'b1) begin bad++; $display("FAIL dbgw_t1_owner got=%b exp=1", bus.owner_o); end
        total++; if (bus.mem_we_o !== 1'b1) begin bad++; $display("FAIL dbgw_t1_we got=%b exp=1", bus.mem_we_o); end
        total++; if (bus.mem_adr_o !== 16'h4020) begin bad++; $display("FAIL dbgw_t1_adr got=%h exp=4020", bus.mem_adr_o); end
        tick();
        dbg_set(1'b0, 1'b0, 16'h4020, 32'h0, 2'b11);
        #2;
        total++; if (bus.dbg_ack_o !== 1'b1) begin bad++; $display("FAIL dbgw_ack got=%b exp=1", bus.dbg_ack_o); end
        total++; if (bus.dbg_err_o !== 1'b0) begin bad++; $display("FAIL dbgw_err got=%b exp=0", bus.dbg_err_o); end
        total++; if (word_at(16'h4020) !== 32'hDEADBEEF) begin bad++; $display("FAIL dbgw_mem got=%h exp=deadbeef", word_at(16'h4020)); end
        // read of the same word
        tick();
        dbg_set(1'b1, 1'b0, 16'h4020, 32'h0, 2'b11);
        #2;
        total++; if (bus.dbg_ack_o !== 1'b0) begin bad++; $display("FAIL dbgr_ack_drop got=%b exp=0", bus.dbg_ack_o); end
        tick(); tick();
        dbg_set(1'b0, 1'b0, 16'h4020, 32'h0, 2'b11);
        #2;
        total++; if (bus.dbg_ack_o !== 1'b1) begin bad++; $display("FAIL dbgr_ack got=%b exp=1", bus.dbg_ack_o); end
        total++; if (bus.dbg_rdata_o !== 32'hDEADBEEF) begin bad++; $display("FAIL dbgr_data got=%h exp=deadbeef", bus.dbg_rdata_o); end
        tick(); #2;
        total++; if (bus.dbg_rdata_o !== 32'hDEADBEEF) begin bad++; $display("FAIL dbgr_data_hold got=%h exp=deadbeef", bus.dbg_rdata_o); end
        tick();
    endtask

    task automatic test_starvation();
        bus.cpu_req_i = 1'b1; bus.cpu_we_i = 1'b0; bus.cpu_adr_i = 16'h4010; bus.cpu_sel_i = 2'b11;
        for (int k = 0; k <= 7; k++) begin
            if (k > 0) tick();
            dbg_set(k < 6, 1'b0, 16'h4020, 32'h0, 2'b11);
            #2;
            total++; if (bus.cpu_stall_o !== (k == 5)) begin bad++; $display("FAIL starve_stall k=%0d got=%b exp=%b", k, bus.cpu_stall_o, (k == 5)); end
            total++; if (bus.owner_o !== (k == 5)) begin bad++; $display("FAIL starve_owner k=%0d got=%b exp=%b", k, bus.owner_o, (k == 5)); end
            total++; if (bus.dbg_ack_o !== (k == 6)) begin bad++; $display("FAIL starve_ack k=%0d got=%b exp=%b", k, bus.dbg_ack_o, (k == 6)); end
            if (k != 5) begin
                total++; if (bus.cpu_rdata_o !== 32'h11223344) begin bad++; $display("FAIL starve_cpu_data k=%0d got=%h exp=11223344", k, bus.cpu_rdata_o); end
            end
        end
        cpu_idle();
        tick();
    endtask

    task automatic test_illegal();
        // CPU word store below base
        bus.cpu_req_i = 1'b1; bus.cpu_we_i = 1'b1; bus.cpu_adr_i = 16'h3FFC;
        bus.cpu_wd_i = 32'h55667788; bus.cpu_sel_i = 2'b11;
        #2;
        total++; if (bus.cpu_err_o !== 1'b1) begin bad++; $display("FAIL ill_sw_err got=%b exp=1", bus.cpu_err_o); end
        total++; if (bus.mem_we_o !== 1'b0) begin bad++; $display("FAIL ill_sw_we got=%b exp=0", bus.mem_we_o); end
        total++; if (bus.cpu_stall_o !== 1'b0) begin bad++; $display("FAIL ill_sw_stall got=%b exp=0", bus.cpu_stall_o); end
        tick();
        // CPU misaligned half store
        bus.cpu_adr_i = 16'h4001; bus.cpu_wd_i = 32'h0000AAAA; bus.cpu_sel_i = 2'b01;
        #2;
        total++; if (bus.cpu_err_o !== 1'b1) begin bad++; $display("FAIL ill_sh_err got=%b exp=1", bus.cpu_err_o); end
        total++; if (bus.mem_we_o !== 1'b0) begin bad++; $display("FAIL ill_sh_we got=%b exp=0", bus.mem_we_o); end
        tick();
        cpu_idle();
        #2;
        total++; if (word_at(16'h3FFC) !== 32'h0) begin bad++; $display("FAIL ill_sw_mem got=%h exp=0", word_at(16'h3FFC)); end
        total++; if (word_at(16'h4000) !== 32'h0) begin bad++; $display("FAIL ill_sh_mem got=%h exp=0", word_at(16'h4000)); end
        // Debug store with sel 10
        tick();
        dbg_set(1'b1, 1'b1, 16'h4010, 32'hFFFFFFFF, 2'b10);
        tick(); #2;
        total++; if (bus.mem_we_o !== 1'b0) begin bad++; $display("FAIL ill_dbg_we got=%b exp=0", bus.mem_we_o); end
        tick();
        dbg_set(1'b0, 1'b0, 16'h4010, 32'h0, 2'b11);
        #2;
        total++; if (bus.dbg_ack_o !== 1'b1) begin bad++; $display("FAIL ill_dbg_ack got=%b exp=1", bus.dbg_ack_o); end
        total++; if (bus.dbg_err_o !== 1'b1) begin bad++; $display("FAIL ill_dbg_err got=%b exp=1", bus.dbg_err_o); end
        total++; if (bus.dbg_rdata_o !== 32'h0) begin bad++; $display("FAIL ill_dbg_rdata got=%h exp=0", bus.dbg_rdata_o); end
        total++; if (word_at(16'h4010) !== 32'h11223344) begin bad++; $display("FAIL ill_dbg_mem got=%h exp=11223344", word_at(16'h4010)); end
        tick();
    endtask

    task automatic test_reset_mid();
        dbg_set(1'b1, 1'b1, 16'h4030, 32'hCAFEF00D, 2'b11);
        tick(); #2;
        total++; if (bus.owner_o !== 1'b1) begin bad++; $display("FAIL rstmid_owner_pre got=%b exp=1", bus.owner_o); end
        #1 rst = 1'b1;
        #1;
        total++; if (bus.owner_o !== 1'b0) begin bad++; $display("FAIL rstmid_owner got=%b exp=0", bus.owner_o); end
        total++; if (bus.mem_we_o !== 1'b0) begin bad++; $display("FAIL rstmid_we got=%b exp=0", bus.mem_we_o); end
        tick();
        rst = 1'b0;
        dbg_set(1'b0, 1'b0, 16'h4030, 32'h0, 2'b11);
        #2;
        total++; if (bus.dbg_ack_o !== 1'b0) begin bad++; $display("FAIL rstmid_ack got=%b exp=0", bus.dbg_ack_o); end
        tick(); #2;
        total++; if (bus.dbg_ack_o !== 1'b0) begin bad++; $display("FAIL rstmid_ack2 got=%b exp=0", bus.dbg_ack_o); end
        total++; if (word_at(16'h4030) !== 32'h0) begin bad++; $display("FAIL rstmid_mem got=%h exp=0", word_at(16'h4030)); end
        tick();
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k <= 5; k++) begin
            if (k > 0) tick();
            dbg_set(k < 4, 1'b0, 16'h4020, 32'h0, 2'b11);
            #2;
            total++; if (bus.dbg_ack_o !== (k == 2 || k == 4)) begin bad++; $display("FAIL held_ack k=%0d got=%b exp=%b", k, bus.dbg_ack_o, (k == 2 || k == 4)); end
            total++; if (bus.owner_o !== (k == 1 || k == 3)) begin bad++; $display("FAIL held_owner k=%0d got=%b exp=%b", k, bus.owner_o, (k == 1 || k == 3)); end
        end
        total++; if (bus.dbg_rdata_o !== 32'hDEADBEEF) begin bad++; $display("FAIL held_data got=%h exp=deadbeef", bus.dbg_rdata_o); end
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        for (int i = 0; i < 65536; i++) mem_b[i] = 8'h00;
        test_reset();
        test_cpu_only();
        test_dbg_idle();
        test_starvation();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
